// File: rtl/freq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// freq_pkg : shared types, range codes and gate-length helper for the
//            frequency-meter gate sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
package freq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_GATE  = 2'd2,
        ST_LOCK  = 2'd3
    } state_t;

    localparam logic [1:0] RNG_X1      = 2'd0;
    localparam logic [1:0] RNG_DIV10   = 2'd1;
    localparam logic [1:0] RNG_DIV100  = 2'd2;
    localparam logic [1:0] RNG_DIV1000 = 2'd3;

    // floor(base / 10^rng); evaluated only at elaboration
    function automatic longint unsigned gate_len(input longint unsigned base,
                                                 input logic [1:0]      rng);
        longint unsigned r;
        r = base;
        for (int i = 0; i < int'(rng); i++) begin
            r = r / 64'd10;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_gate_ctrl_phase_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// phase_timer : loadable down-counter with a zero flag, shared by all
//               measurement phases. Holds at zero, never wraps.
// Rev 1.0
// ---------------------------------------------------------------------------
module phase_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/freq_gate_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// freq_gate_ctrl : clear / gate / lock sequencer for the frequency meter,
//                  single-shot or continuous, four decade gate ranges.
// Rev 1.0
// ---------------------------------------------------------------------------
module freq_gate_ctrl
    import freq_pkg::*;
#(
    parameter int BASE_CYC = 50_000_000,
    parameter int GATE_W   = 32,
    parameter int CLR_CYC  = 2,
    parameter int LOCK_CYC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cont,
    input  logic [1:0] range_sel,
    output logic       enable,
    output logic       clr,
    output logic       lock,
    output logic       busy,
    output logic       done
);

    if (BASE_CYC < 1000 || CLR_CYC < 1 || LOCK_CYC < 1 || GATE_W < 1 ||
        (GATE_W < 63 && (64'(BASE_CYC) >> GATE_W) != 64'd0)) begin : g_param_check
        $error("freq_gate_ctrl: illegal parameter set");
    end

    // Timer reload values are length-1 because the zero cycle is the last one
    localparam logic [GATE_W-1:0] CLR_LD  = GATE_W'(CLR_CYC - 1);
    localparam logic [GATE_W-1:0] LOCK_LD = GATE_W'(LOCK_CYC - 1);
    localparam logic [GATE_W-1:0] GATE_LD [4] = '{
        GATE_W'(gate_len(64'(BASE_CYC), RNG_X1)      - 64'd1),
        GATE_W'(gate_len(64'(BASE_CYC), RNG_DIV10)   - 64'd1),
        GATE_W'(gate_len(64'(BASE_CYC), RNG_DIV100)  - 64'd1),
        GATE_W'(gate_len(64'(BASE_CYC), RNG_DIV1000) - 64'd1)
    };

    state_t             state_q, state_d;
    logic [1:0]         rng_q, rng_d;
    logic               tmr_load;
    logic [GATE_W-1:0]  tmr_val;
    logic               tmr_zero;
    logic               enable_d, clr_d, lock_d, busy_d, done_d;

    phase_timer #(
        .W (GATE_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            rng_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rng_q   <= rng_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rng_d    = rng_q;
        tmr_load = 1'b0;
        tmr_val  = CLR_LD;
        case (state_q)
            ST_IDLE: begin
                if (start || cont) begin
                    state_d  = ST_CLEAR;
                    rng_d    = range_sel;
                    tmr_load = 1'b1;
                    tmr_val  = CLR_LD;
                end
            end
            ST_CLEAR: begin
                if (tmr_zero) begin
                    state_d  = ST_GATE;
                    tmr_load = 1'b1;
                    tmr_val  = GATE_LD[rng_q];
                end
            end
            ST_GATE: begin
                if (tmr_zero) begin
                    state_d  = ST_LOCK;
                    tmr_load = 1'b1;
                    tmr_val  = LOCK_LD;
                end
            end
            ST_LOCK: begin
                if (tmr_zero) begin
                    if (cont) begin
                        state_d  = ST_CLEAR;
                        rng_d    = range_sel;
                        tmr_load = 1'b1;
                        tmr_val  = CLR_LD;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it
    always_comb begin
        enable_d = (state_d == ST_GATE);
        clr_d    = (state_d == ST_CLEAR);
        lock_d   = (state_d == ST_LOCK);
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q == ST_LOCK) && tmr_zero;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= 1'b0;
            clr    <= 1'b0;
            lock   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            enable <= enable_d;
            clr    <= clr_d;
            lock   <= lock_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_freq_gate_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_freq_gate_ctrl : scoreboard bench; each measurement's expected phase
//                     lengths are queued at stimulus time and checked on done.
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_freq_gate_ctrl;

    localparam int BASE  = 1000;
    localparam int CLRC  = 2;
    localparam int LOCKC = 1;

    typedef struct {
        int en;
        int bsy;
        int bdone;
        int cdone;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic [1:0] range_sel = 2'd0;
    logic       enable, clr, lock, busy, done;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_clr = 0, n_en = 0, n_lock = 0, n_bsy = 0, ord_err = 0;

    freq_gate_ctrl #(
        .BASE_CYC (BASE),
        .GATE_W   (16),
        .CLR_CYC  (CLRC),
        .LOCK_CYC (LOCKC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cont      (cont),
        .range_sel (range_sel),
        .enable    (enable),
        .clr       (clr),
        .lock      (lock),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: accumulates phase lengths and scores each measurement on done
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            n_clr = 0; n_en = 0; n_lock = 0; n_bsy = 0; ord_err = 0;
        end else begin
            if (done) begin
                n_done++;
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("enable_cycles", n_en, e.en);
                    chk("clr_cycles", n_clr, CLRC);
                    chk("lock_cycles", n_lock, LOCKC);
                    chk("busy_cycles", n_bsy, e.bsy);
                    chk("busy_at_done", int'(busy), e.bdone);
                    chk("clr_at_done", int'(clr), e.cdone);
                    chk("phase_order_mutex", ord_err, 0);
                end
                n_clr = 0; n_en = 0; n_lock = 0; n_bsy = 0; ord_err = 0;
            end
            if (int'(enable) + int'(clr) + int'(lock) > 1) ord_err = 1;
            if (clr && (n_en > 0 || n_lock > 0)) ord_err = 1;
            if (enable && n_lock > 0) ord_err = 1;
            if (clr)    n_clr++;
            if (enable) n_en++;
            if (lock)   n_lock++;
            if (busy)   n_bsy++;
        end
    end

    task automatic push_exp(input int en, input int bdone, input int cdone);
        exp_t e;
        e.en = en; e.bsy = CLRC + en + LOCKC; e.bdone = bdone; e.cdone = cdone;
        q.push_back(e);
    endtask

    task automatic pulse_start(input logic [1:0] r);
        @(posedge clk); #1 start = 1'b1; range_sel = r;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("start_to_clr", int'(clr), 1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int c = 0;
        while (n_done < target && c < budget) begin
            @(posedge clk);
            c++;
        end
        if (n_done < target) chk("done_timeout", n_done, target);
    endtask

    initial begin
        int b;
        int gl[4] = '{1000, 100, 10, 1};

        #12;
        chk("reset_outputs", int'({enable, clr, lock, busy, done}), 0);
        @(posedge clk); #3 reset = 1'b0;

        // single-shot, all four ranges
        for (int r = 0; r < 4; r++) begin
            b = n_done;
            push_exp(gl[r], 0, 0);
            pulse_start(2'(r));
            wait_done(b + 1, 1100);
        end

        // continuous range 2: five runs, then three runs
        for (int k = 0; k < 2; k++) begin
            int m = (k == 0) ? 5 : 3;
            b = n_done;
            for (int i = 0; i < m - 1; i++) push_exp(10, 1, 1);
            push_exp(10, 0, 0);
            @(posedge clk); #1 cont = 1'b1; range_sel = 2'd2;
            wait_done(b + m - 1, 15 * m);
            repeat (3) @(posedge clk);
            #1 cont = 1'b0;
            wait_done(b + m, 30);
            repeat (5) @(posedge clk);
        end

        // range switch 0->3 while gating in continuous mode
        b = n_done;
        push_exp(1000, 1, 1);
        push_exp(1, 0, 0);
        @(posedge clk); #1 cont = 1'b1; range_sel = 2'd0;
        repeat (50) @(posedge clk);
        #1 range_sel = 2'd3;
        wait_done(b + 1, 1100);
        #1 cont = 1'b0;
        wait_done(b + 2, 20);

        // start during GATE is ignored
        b = n_done;
        push_exp(10, 0, 0);
        pulse_start(2'd2);
        repeat (4) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(b + 1, 40);
        repeat (30) @(posedge clk);
        chk("no_extra_done", n_done, b + 1);

        // async reset mid-GATE, then a normal measurement
        b = n_done;
        pulse_start(2'd0);
        repeat (100) @(posedge clk);
        #3 reset = 1'b1;
        #1 chk("async_reset_outputs", int'({enable, clr, lock, busy, done}), 0);
        repeat (20) @(posedge clk);
        #3 reset = 1'b0;
        chk("no_done_after_reset", n_done, b);
        push_exp(1, 0, 0);
        pulse_start(2'd3);
        wait_done(b + 1, 20);

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/freq_gate_ctrl.md
# freq_gate_ctrl

Parametrised gate/clear/lock sequencer for the frequency-meter datapath, clocked by the system clock. Each measurement runs a clear phase for the pulse counters, an enable (gate) window of exactly N clock cycles, and a lock phase for the display latches. N is chosen at run time from four decade ranges. The block supports single-shot and continuous operation, and reports busy/done to the display/control logic.

## Interface
- `BASE_CYC`, default 50_000_000: gate length of range 0, in clk cycles (1 s at 50 MHz). Must be ≥ 1000.
- `GATE_W`, default 32: gate counter width. Must satisfy 2^GATE_W > BASE_CYC; enforced by an elaboration check.
- `CLR_CYC`, default 2: clear phase length in cycles, ≥ 1.
- `LOCK_CYC`, default 1: lock phase length in cycles, ≥ 1.
- `clk` input 1: single system clock, rising edge.
- `reset` input 1: **asynchronous, active-high** reset.
- `start` input 1: single-shot request, sampled in IDLE.
- `cont` input 1: continuous mode request, level.
- `range_sel` input 2: gate length selection. 0 → BASE_CYC, 1 → BASE_CYC/10, 2 → /100, 3 → /1000 (floor).
- `enable` output 1: counter gate.
- `clr` output 1: counter clear.
- `lock` output 1: result latch strobe.
- `busy` output 1: high whenever the state is not IDLE.
- `done` output 1: one-cycle pulse marking the end of each measurement.

## Operation
- FSM states: IDLE, CLEAR, GATE, LOCK. Every output is a flop, and all outputs reset to 0.
- IDLE:
  - `start` or `cont` sampled high → CLEAR.
  - `range_sel` is latched into `rng_q` on this transition.
  - `start` while busy is ignored and is not queued.
- CLEAR:
  - `clr`=1 and `enable`=0 for CLR_CYC cycles → GATE.
  - The phase counter is loaded with the selected gate length −1.
- GATE: `enable`=1 for exactly gate_len(`rng_q`) cycles → LOCK.
- LOCK: `lock`=1 for LOCK_CYC cycles, then `done` pulses for 1 cycle on the following cycle. That cycle is entered as:
  - CLEAR if `cont` is high at the last LOCK cycle. `range_sel` is re-latched, with no idle gap.
  - IDLE otherwise.
- `enable`, `clr` and `lock` are mutually exclusive in every cycle.
- Dropping `cont` mid-measurement completes the current measurement (done still pulses), then the FSM goes to IDLE.
- A `range_sel` change mid-measurement has no effect until the next CLEAR entry.
- `reset` asserted mid-operation: immediately IDLE, all outputs 0, counters 0. The partial measurement is discarded and no `done` is issued.
- Gate lengths are constants computed at elaboration. Gate counter arithmetic is unsigned GATE_W, counting down to 0, with no wrap-around.

## Timing
- `start` high at edge k → `clr` high during cycles k+1 … k+CLR_CYC.
- `enable` high during the next gate_len cycles, then `lock` high during the next LOCK_CYC cycles.
- `done` is high in cycle k+CLR_CYC+gate_len+LOCK_CYC+1. In continuous mode, `clr` is high in that same cycle.
- `busy` rises at k+1. In single-shot mode it falls in the same cycle `done` rises.
- Continuous period = CLR_CYC + gate_len + LOCK_CYC cycles, exactly.
- Reset deassertion is synchronised externally. The first FSM action can occur at the first edge after release.

## Structure
- Shared package `freq_pkg` holds:
  - the state enum (IDLE/CLEAR/GATE/LOCK);
  - the range encoding constants;
  - the function `gate_len(base, rng)` returning floor(base/10^rng).
- Natural sub-module: `phase_timer`, a loadable GATE_W down-counter with a `zero` flag. It is shared by the CLEAR, GATE and LOCK phases.

## Test plan
Bench parameters for all scenarios: BASE_CYC=1000, CLR_CYC=2, LOCK_CYC=1.
- Single-shot, range 0: `start` pulse at edge 10 → clr in cycles 11–12, enable in 13–1012, lock in 1013, done and busy↓ in 1014.
- Ranges 1, 2 and 3 in single-shot: enable high for exactly 100, 10 and 1 cycles respectively. Count the enable cycles.
- Continuous, range 2: 5 back-to-back measurements with period 13 cycles and 5 done pulses. `cont` dropped during the 3rd GATE → 3rd completes with done, then IDLE.
- `range_sel` switched 0→3 during GATE → current gate is 1000 cycles, and the next continuous gate is 1 cycle.
- `start` pulsed during GATE → ignored, and only one done results.
- Async `reset` asserted mid-GATE between clock edges → all outputs 0 immediately, no done. After release, `start` gives the normal sequence.
